// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared widths and shift constants for the butterfly datapath
package bf_pkg;

    // Default operand widths: data in Q1.7, twiddle sum/difference in Q2.7
    localparam int DATA_W    = 8;
    localparam int TW_W      = 9;

    // Product rescale back to Q1.7, and the halving applied to the butterfly outputs
    localparam int SHIFT_P   = 7;
    localparam int SHIFT_OUT = 1;

    // Derived widths, sized so no intermediate result can overflow
    localparam int DIFF_W    = DATA_W + 1;          // B_re - B_im
    localparam int PROD_W    = DIFF_W + DATA_W;     // each of the three products
    localparam int SUM_W     = PROD_W + 1;          // product + K
    localparam int SCL_W     = SUM_W - SHIFT_P;     // P after rescale
    localparam int ADD_W     = SCL_W;               // A +/- P before halving

endpackage

// File: rtl/cmult3.sv
// rtl/cmult3.sv - three-multiplier complex multiply P = B * (C + jS), stages S1-S2
module cmult3
    import bf_pkg::SHIFT_P;
#(
    parameter  int DATA_W = bf_pkg::DATA_W,
    parameter  int TW_W   = bf_pkg::TW_W,
    localparam int DIFF_W = DATA_W + 1,
    localparam int PROD_W = DIFF_W + DATA_W,
    localparam int SUM_W  = PROD_W + 1,
    localparam int SCL_W  = SUM_W - SHIFT_P
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] i_b_re,
    input  logic signed [DATA_W-1:0] i_b_im,
    input  logic signed [DATA_W-1:0] i_c,
    input  logic signed [TW_W-1:0]   i_c_plus_s,
    input  logic signed [TW_W-1:0]   i_c_minus_s,
    output logic signed [SCL_W-1:0]  o_p_re,
    output logic signed [SCL_W-1:0]  o_p_im
);

    logic signed [DATA_W-1:0] r_b_re;
    logic signed [DATA_W-1:0] r_b_im;
    logic signed [DATA_W-1:0] r_c;
    logic signed [TW_W-1:0]   r_cps;
    logic signed [TW_W-1:0]   r_cms;

    logic signed [PROD_W-1:0] r_k;
    logic signed [PROD_W-1:0] r_m_re;
    logic signed [PROD_W-1:0] r_m_im;

    logic signed [DIFF_W-1:0] w_diff;
    logic signed [SUM_W-1:0]  w_sum_re;
    logic signed [SUM_W-1:0]  w_sum_im;

    // Shared term K uses the S1 copy of B; operands are widened before multiplying
    assign w_diff = DIFF_W'(r_b_re) - DIFF_W'(r_b_im);

    // S1: capture operands every cycle; validity is tracked by the caller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_b_re <= '0;
            r_b_im <= '0;
            r_c    <= '0;
            r_cps  <= '0;
            r_cms  <= '0;
        end else begin
            r_b_re <= i_b_re;
            r_b_im <= i_b_im;
            r_c    <= i_c;
            r_cps  <= i_c_plus_s;
            r_cms  <= i_c_minus_s;
        end
    end

    // S2: the three multiplies, registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k    <= '0;
            r_m_re <= '0;
            r_m_im <= '0;
        end else begin
            r_k    <= PROD_W'(w_diff) * PROD_W'(r_c);
            r_m_re <= PROD_W'(r_cms) * PROD_W'(r_b_im);
            r_m_im <= PROD_W'(r_cps) * PROD_W'(r_b_re);
        end
    end

    // Recombine with K and rescale; arithmetic shift floors toward minus infinity
    assign w_sum_re = SUM_W'(r_m_re) + SUM_W'(r_k);
    assign w_sum_im = SUM_W'(r_m_im) - SUM_W'(r_k);
    assign o_p_re   = SCL_W'(w_sum_re >>> SHIFT_P);
    assign o_p_im   = SCL_W'(w_sum_im >>> SHIFT_P);

endmodule

// File: rtl/bf_processor.sv
// rtl/bf_processor.sv - radix-2 butterfly D/E = (A +/- B*W) / 2, three-stage pipeline
module bf_processor
    import bf_pkg::SHIFT_P;
    import bf_pkg::SHIFT_OUT;
#(
    parameter  int DATA_W = bf_pkg::DATA_W,
    parameter  int TW_W   = bf_pkg::TW_W,
    localparam int SCL_W  = DATA_W + 1 + DATA_W + 1 - SHIFT_P,
    localparam int ADD_W  = SCL_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_calc,
    input  logic signed [DATA_W-1:0] A_re,
    input  logic signed [DATA_W-1:0] A_im,
    input  logic signed [DATA_W-1:0] B_re,
    input  logic signed [DATA_W-1:0] B_im,
    input  logic signed [DATA_W-1:0] i_C,
    input  logic signed [TW_W-1:0]   C_plus_S,
    input  logic signed [TW_W-1:0]   C_minus_S,
    output logic signed [DATA_W-1:0] D_re,
    output logic signed [DATA_W-1:0] D_im,
    output logic signed [DATA_W-1:0] E_re,
    output logic signed [DATA_W-1:0] E_im,
    output logic                     calc_done
);

    logic                     r_v1;
    logic                     r_v2;
    logic signed [DATA_W-1:0] r_a1_re;
    logic signed [DATA_W-1:0] r_a1_im;
    logic signed [DATA_W-1:0] r_a2_re;
    logic signed [DATA_W-1:0] r_a2_im;

    logic signed [SCL_W-1:0]  w_p_re;
    logic signed [SCL_W-1:0]  w_p_im;
    logic signed [ADD_W-1:0]  w_sum_d_re;
    logic signed [ADD_W-1:0]  w_sum_d_im;
    logic signed [ADD_W-1:0]  w_sum_e_re;
    logic signed [ADD_W-1:0]  w_sum_e_im;

    cmult3 #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W)
    ) u_cmult3 (
        .clk         (clk),
        .reset       (reset),
        .i_b_re      (B_re),
        .i_b_im      (B_im),
        .i_c         (i_C),
        .i_c_plus_s  (C_plus_S),
        .i_c_minus_s (C_minus_S),
        .o_p_re      (w_p_re),
        .o_p_im      (w_p_im)
    );

    // Valid bits follow the data; only a sampled start_calc creates one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            calc_done <= 1'b0;
        end else begin
            r_v1      <= start_calc;
            r_v2      <= r_v1;
            calc_done <= r_v2;
        end
    end

    // A is delayed two stages to line up with P coming out of the multiplier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a1_re <= '0;
            r_a1_im <= '0;
            r_a2_re <= '0;
            r_a2_im <= '0;
        end else begin
            r_a1_re <= A_re;
            r_a1_im <= A_im;
            r_a2_re <= r_a1_re;
            r_a2_im <= r_a1_im;
        end
    end

    // Sign-extended add/sub; halving then keeping the low bits wraps on overflow
    assign w_sum_d_re = ADD_W'(r_a2_re) + ADD_W'(w_p_re);
    assign w_sum_d_im = ADD_W'(r_a2_im) + ADD_W'(w_p_im);
    assign w_sum_e_re = ADD_W'(r_a2_re) - ADD_W'(w_p_re);
    assign w_sum_e_im = ADD_W'(r_a2_im) - ADD_W'(w_p_im);

    // S3: outputs update only for a valid result and otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_re <= '0;
            D_im <= '0;
            E_re <= '0;
            E_im <= '0;
        end else if (r_v2) begin
            D_re <= DATA_W'(w_sum_d_re >>> SHIFT_OUT);
            D_im <= DATA_W'(w_sum_d_im >>> SHIFT_OUT);
            E_re <= DATA_W'(w_sum_e_re >>> SHIFT_OUT);
            E_im <= DATA_W'(w_sum_e_im >>> SHIFT_OUT);
        end
    end

endmodule

// File: tb/tb_bf_processor.sv
// tb/tb_bf_processor.sv - self-checking bench for bf_processor
module tb_bf_processor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_calc;
    logic [7:0] a_re, a_im, b_re, b_im, c;
    logic [8:0] cps, cms;
    logic [7:0] d_re, d_im, e_re, e_im;
    logic       calc_done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] a_re, a_im, b_re, b_im, c;
        logic [8:0] cps, cms;
        logic [7:0] d_re, d_im, e_re, e_im;
    } vec_t;

    vec_t        vecs[3];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    bf_processor dut (
        .clk        (clk),
        .reset      (reset),
        .start_calc (start_calc),
        .A_re       (a_re),
        .A_im       (a_im),
        .B_re       (b_re),
        .B_im       (b_im),
        .i_C        (c),
        .C_plus_S   (cps),
        .C_minus_S  (cms),
        .D_re       (d_re),
        .D_im       (d_im),
        .E_re       (e_re),
        .E_im       (e_im),
        .calc_done  (calc_done)
    );

    // Reference butterfly in plain integer arithmetic; >>> on int is floor division
    function automatic logic [31:0] model(input logic [7:0] ar, ai, br, bi, cc,
                                          input logic [8:0] ps, ms);
        int k, pr, pi, dr, di, er, ei;
        k  = (int'($signed(br)) - int'($signed(bi))) * int'($signed(cc));
        pr = (int'($signed(ms)) * int'($signed(bi)) + k) >>> 7;
        pi = (int'($signed(ps)) * int'($signed(br)) - k) >>> 7;
        dr = (int'($signed(ar)) + pr) >>> 1;
        di = (int'($signed(ai)) + pi) >>> 1;
        er = (int'($signed(ar)) - pr) >>> 1;
        ei = (int'($signed(ai)) - pi) >>> 1;
        return {dr[7:0], di[7:0], er[7:0], ei[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a_re = 8'($urandom); a_im = 8'($urandom);
        b_re = 8'($urandom); b_im = 8'($urandom);
        c    = 8'($urandom);
        cps  = 9'($urandom); cms  = 9'($urandom);
    endtask

    task automatic set_vec(input vec_t v);
        a_re = v.a_re; a_im = v.a_im; b_re = v.b_re; b_im = v.b_im;
        c = v.c; cps = v.cps; cms = v.cms;
    endtask

    function automatic logic [31:0] outs();
        return {d_re, d_im, e_re, e_im};
    endfunction

    // Single start, then done must appear after the third edge only, for one cycle
    task automatic run_single(input string name, input logic [31:0] exp);
        start_calc = 1'b1;
        step();
        start_calc = 1'b0;
        rand_ops();
        chk({name, "_done_e1"}, {31'd0, calc_done}, 32'd0);
        step();
        chk({name, "_done_e2"}, {31'd0, calc_done}, 32'd0);
        step();
        chk({name, "_done_e3"}, {31'd0, calc_done}, 32'd1);
        chk({name, "_result"}, outs(), exp);
        step();
        chk({name, "_done_e4"}, {31'd0, calc_done}, 32'd0);
        chk({name, "_hold"}, outs(), exp);
    endtask

    initial begin
        logic [31:0] last;
        logic [31:0] e;
        bit          have_last;
        int          issued;
        int          cyc;

        vecs[0] = '{8'h62, 8'h52, 8'h46, 8'h32, 8'h6E, 9'h0AE, 9'h02E, 8'h42, 8'h4F, 8'h1F, 8'h02};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 9'h000, 9'h000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 8'h00, 8'h40, 8'h00, 8'h7F, 9'h07F, 9'h07F, 8'h1F, 8'h00, 8'hE0, 8'h00};

        // Reset state
        reset = 1'b1;
        start_calc = 1'b0;
        rand_ops();
        step();
        step();
        chk("reset_outs", outs(), 32'd0);
        chk("reset_done", {31'd0, calc_done}, 32'd0);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 3; i++) begin
            set_vec(vecs[i]);
            chk($sformatf("model_vec%0d", i), model(vecs[i].a_re, vecs[i].a_im, vecs[i].b_re,
                vecs[i].b_im, vecs[i].c, vecs[i].cps, vecs[i].cms),
                {vecs[i].d_re, vecs[i].d_im, vecs[i].e_re, vecs[i].e_im});
            run_single($sformatf("vec%0d", i),
                       {vecs[i].d_re, vecs[i].d_im, vecs[i].e_re, vecs[i].e_im});
            step();
        end

        // Four back-to-back starts with changing operands
        exp_q.delete();
        for (int j = 0; j < 4; j++) begin
            rand_ops();
            start_calc = 1'b1;
            exp_q.push_back(model(a_re, a_im, b_re, b_im, c, cps, cms));
            step();
            chk($sformatf("b2b_done_step%0d", j), {31'd0, calc_done}, {31'd0, j >= 2});
            if (calc_done && exp_q.size() > 0) chk("b2b_result", outs(), exp_q.pop_front());
        end
        start_calc = 1'b0;
        for (int j = 4; j < 8; j++) begin
            rand_ops();
            step();
            chk($sformatf("b2b_done_step%0d", j), {31'd0, calc_done}, {31'd0, j < 6});
            if (calc_done && exp_q.size() > 0) chk("b2b_result", outs(), exp_q.pop_front());
        end
        chk("b2b_drained", exp_q.size(), 32'd0);

        // Reset one cycle after start discards the calculation
        set_vec(vecs[0]);
        start_calc = 1'b1;
        step();
        start_calc = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_outs", outs(), 32'd0);
        chk("midrst_done", {31'd0, calc_done}, 32'd0);
        step();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("midrst_nodone%0d", j), {31'd0, calc_done}, 32'd0);
        end
        chk("midrst_outs_after", outs(), 32'd0);
        set_vec(vecs[2]);
        run_single("post_rst", {vecs[2].d_re, vecs[2].d_im, vecs[2].e_re, vecs[2].e_im});

        // Reset release then immediate start: first edge after release samples it
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_vec(vecs[0]);
        run_single("rel_start", {vecs[0].d_re, vecs[0].d_im, vecs[0].e_re, vecs[0].e_im});

        // Random streaming against the model with an in-order scoreboard
        exp_q.delete();
        have_last = 1'b0;
        last = '0;
        issued = 0;
        cyc = 0;
        while (issued < 1000 && cyc < 5000) begin
            rand_ops();
            start_calc = ($urandom_range(0, 3) != 0);
            if (start_calc) begin
                exp_q.push_back(model(a_re, a_im, b_re, b_im, c, cps, cms));
                issued++;
            end
            step();
            cyc++;
            if (calc_done) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious_done", {31'd0, calc_done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_result", outs(), e);
                    last = e;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk("rand_hold", outs(), last);
            end
        end
        chk("rand_issued", issued, 32'd1000);
        start_calc = 1'b0;
        for (int j = 0; j < 6 && exp_q.size() > 0; j++) begin
            step();
            if (calc_done && exp_q.size() > 0) chk("rand_drain", outs(), exp_q.pop_front());
        end
        chk("rand_all_done", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
